sram_bridge: RTL
================

# sram_bridge

Parametrised bridge between the CPU's word-wide memory port and the narrow external SRAM used by `Ram`. It supersedes the fixed 32→16 path in `MemController` with configurable CPU width, SRAM width, address width and wait states. It splits each request into little-endian SRAM beats, drives per-lane byte masks, skips write beats with no enabled bytes, and returns one response per request.

## Interface
- `CPU_W`, 32: CPU data width in bits; must be a multiple of `SRAM_W`.
- `SRAM_W`, 16: SRAM data width; fixed to two byte lanes (hb/lb).
- `ADDR_W`, 18: SRAM address width, in SRAM words.
- `WAIT`, 1: extra cycles each beat is held; 0..7.

Ports:
- `clock`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: bridge idle and able to accept.
- `req_we`  in  1: 1 = write, 0 = read.
- `req_addr`  in  32: byte address; low log2(CPU_W/8) bits are ignored.
- `req_wdata`  in  CPU_W: write data.
- `req_be`  in  CPU_W/8: byte enables for writes; ignored on reads.
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_rdata`  out  CPU_W: read data, valid with `rsp_valid` on reads.
- `addr`  out  ADDR_W: SRAM word address.
- `wdata`  out  SRAM_W: SRAM write data.
- `rdata`  in  SRAM_W: SRAM read data.
- `data_oe`  out  1: drive `wdata` onto the shared bus; the top level resolves the tristate.
- `wre`, `oute`, `chip_en`  out  1 each: write enable, output enable, chip enable. All active-high.
- `hb_mask`, `lb_mask`  out  1 each: 1 = byte lane disabled.

## Operation
- BEATS = CPU_W/SRAM_W. Beat b carries CPU bits [b·SRAM_W +: SRAM_W].
- Beat b address = (req_addr >> log2(CPU_W/8))·BEATS + b, truncated to ADDR_W. Wrap-around at 2^ADDR_W is silent.
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid` it latches the request and moves to BEAT. For a write with `req_be`==0 it goes directly to DONE.
  - BEAT: holds `chip_en`=1 with the current beat's addr, masks and data for WAIT+1 cycles. Reads assert `oute`=1 and `hb_mask`=`lb_mask`=0, and capture `rdata` on the last cycle of the beat. Writes assert `wre`=1 and `data_oe`=1, with masks equal to the inverted enables for that beat.
  - Beat advance: moves to the next beat that has a nonzero enable. Reads never skip a beat. After the last beat it goes to DONE.
  - DONE: `rsp_valid`=1 and all SRAM controls are 0. Returns to IDLE the next cycle.
- `rsp_rdata` holds its last value until the next read completes. Write responses do not modify it.
- `req_valid` is ignored outside IDLE, and request inputs are sampled only at acceptance.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, addr/wdata=0, all controls 0.
- Every SRAM-side output is registered. Outputs change only at beat boundaries, so addr and data are stable for the whole beat.
- Latency from the acceptance edge to `rsp_valid` is N·(WAIT+1)+1 cycles, where N is the number of beats issued. With defaults: read = 5 cycles, full write = 5, one-half write = 3, be==0 write = 1.
- Throughput: the next request can be accepted in the cycle after DONE.
- Asserting `reset` mid-transaction forces all outputs to reset values immediately and abandons the transaction with no response. After `reset` falls the bridge is in IDLE.

## Structure
- Package `sram_bridge_pkg`: state enum (IDLE, BEAT, DONE), BEATS, beat-counter width, and wait-counter width.
- No sub-module. Beat selection, wait counter and lane masking are all inline.

## Test plan
- Reset, then a read from 0x10 with SRAM[8]=0x5678 and SRAM[9]=0x1234 → addr 8 then 9, each held 2 cycles; `rsp_rdata`=0x12345678 five cycles after acceptance.
- Write 0xDEADBEEF to 0x20 with be=0xF → SRAM[16]=0xBEEF, SRAM[17]=0xDEAD, both masks 0 throughout, `rsp_valid` after 5 cycles.
- Write with be=0x4 to 0x20, data 0x00AA0000 → only beat 1 is issued, `hb_mask`=1, `lb_mask`=0, SRAM[17] low byte=0xAA, `rsp_valid` after 3 cycles.
- Write with be=0 → no `chip_en`, `rsp_valid` on the next cycle.
- Assert `reset` during beat 1 of a read → all outputs 0 and `req_ready`=1 at once, no `rsp_valid`; a following read completes normally.
- WAIT=0 build with `req_valid` held high across back-to-back reads → 3-cycle latency each, second request accepted in the cycle after DONE.

Source files
------------

// File: rtl/sram_bridge_pkg.sv
// Shared types and sizing helpers for the CPU-to-narrow-SRAM bridge.
package sram_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBeat,
        StDone
    } state_t;

    localparam int unsigned WAIT_CNT_W = 3;
    localparam int unsigned BEATS      = 32 / 16;

    function automatic int unsigned calc_beats(input int unsigned cpu_w, input int unsigned sram_w);
        return cpu_w / sram_w;
    endfunction

    function automatic int unsigned calc_bcnt_w(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/sram_bridge.sv
// Splits CPU word requests into little-endian SRAM beats with per-lane masks and wait states,
// returning one response pulse per request.
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int unsigned CPU_W  = 32,
    parameter int unsigned SRAM_W = 16,
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned WAIT   = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [CPU_W-1:0]    req_wdata,
    input  logic [CPU_W/8-1:0]  req_be,
    output logic                rsp_valid,
    output logic [CPU_W-1:0]    rsp_rdata,
    output logic [ADDR_W-1:0]   addr,
    output logic [SRAM_W-1:0]   wdata,
    input  logic [SRAM_W-1:0]   rdata,
    output logic                data_oe,
    output logic                wre,
    output logic                oute,
    output logic                chip_en,
    output logic                hb_mask,
    output logic                lb_mask
);

    localparam int unsigned NBEATS = calc_beats(CPU_W, SRAM_W);
    localparam int unsigned BCNT_W = calc_bcnt_w(NBEATS);
    localparam int unsigned OFF_W  = $clog2(CPU_W / 8);
    localparam int unsigned BE_W   = CPU_W / 8;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT);

    state_t                  r_state;
    logic                    r_we;
    logic [ADDR_W-1:0]       r_base;
    logic [CPU_W-1:0]        r_wbuf;
    logic [CPU_W-1:0]        r_rbuf;
    logic [BE_W-1:0]         r_be;
    logic [BCNT_W-1:0]       r_beat;
    logic [WAIT_CNT_W-1:0]   r_wait;
    logic                    r_rsp_valid;
    logic [CPU_W-1:0]        r_rsp_rdata;
    logic [ADDR_W-1:0]       r_addr;
    logic [SRAM_W-1:0]       r_wdata;
    logic                    r_data_oe, r_wre, r_oute, r_chip_en, r_hb_mask, r_lb_mask;

    logic                    w_adv;
    logic                    w_src_we;
    logic [BE_W-1:0]         w_src_be;
    logic [CPU_W-1:0]        w_src_wdata;
    logic [ADDR_W-1:0]       w_src_base;
    logic [ADDR_W-1:0]       w_req_base;
    logic [BCNT_W:0]         w_start;
    logic                    w_found;
    logic [BCNT_W-1:0]       w_idx;
    logic [1:0]              w_lanes;
    logic [ADDR_W-1:0]       w_beat_addr;
    logic [SRAM_W-1:0]       w_beat_data;
    logic [CPU_W-1:0]        w_rbuf_next;

    assign w_req_base = ADDR_W'((req_addr >> OFF_W) * NBEATS);
    assign w_adv = ((r_state == StIdle) && req_valid) ||
                   ((r_state == StBeat) && (r_wait == WAIT_LAST));

    // The beat search runs on the live request in IDLE and on the latched one afterwards.
    always_comb begin
        if (r_state == StIdle) begin
            w_src_we    = req_we;
            w_src_be    = req_be;
            w_src_wdata = req_wdata;
            w_src_base  = w_req_base;
            w_start     = '0;
        end else begin
            w_src_we    = r_we;
            w_src_be    = r_be;
            w_src_wdata = r_wbuf;
            w_src_base  = r_base;
            w_start     = {1'b0, r_beat} + 1'b1;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int b = NBEATS - 1; b >= 0; b--) begin
            if ((b >= int'(w_start)) && (!w_src_we || (w_src_be[2*b +: 2] != 2'b00))) begin
                w_found = 1'b1;
                w_idx   = BCNT_W'(b);
            end
        end
    end

    assign w_lanes     = w_src_be[2*w_idx +: 2];
    assign w_beat_addr = w_src_base + ADDR_W'(w_idx);
    assign w_beat_data = w_src_wdata[w_idx*SRAM_W +: SRAM_W];

    always_comb begin
        w_rbuf_next = r_rbuf;
        w_rbuf_next[r_beat*SRAM_W +: SRAM_W] = rdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_we        <= 1'b0;
            r_base      <= '0;
            r_wbuf      <= '0;
            r_rbuf      <= '0;
            r_be        <= '0;
            r_beat      <= '0;
            r_wait      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_data_oe   <= 1'b0;
            r_wre       <= 1'b0;
            r_oute      <= 1'b0;
            r_chip_en   <= 1'b0;
            r_hb_mask   <= 1'b0;
            r_lb_mask   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_we   <= req_we;
                        r_base <= w_req_base;
                        r_wbuf <= req_wdata;
                        r_be   <= req_be;
                    end
                end
                StBeat: begin
                    if (r_wait != WAIT_LAST) begin
                        r_wait <= r_wait + 1'b1;
                    end else if (!r_we) begin
                        r_rbuf <= w_rbuf_next;
                    end
                end
                StDone: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= StIdle;
                end
                default: r_state <= StIdle;
            endcase

            if (w_adv) begin
                r_wait <= '0;
                if (w_found) begin
                    r_state   <= StBeat;
                    r_beat    <= w_idx;
                    r_addr    <= w_beat_addr;
                    r_chip_en <= 1'b1;
                    r_oute    <= !w_src_we;
                    r_wre     <= w_src_we;
                    r_data_oe <= w_src_we;
                    r_wdata   <= w_src_we ? w_beat_data : '0;
                    r_hb_mask <= w_src_we & ~w_lanes[1];
                    r_lb_mask <= w_src_we & ~w_lanes[0];
                end else begin
                    r_state     <= StDone;
                    r_rsp_valid <= 1'b1;
                    r_chip_en   <= 1'b0;
                    r_oute      <= 1'b0;
                    r_wre       <= 1'b0;
                    r_data_oe   <= 1'b0;
                    r_hb_mask   <= 1'b0;
                    r_lb_mask   <= 1'b0;
                    if ((r_state == StBeat) && !r_we) begin
                        r_rsp_rdata <= w_rbuf_next;
                    end
                end
            end
        end
    end

    assign req_ready = (r_state == StIdle);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign addr      = r_addr;
    assign wdata     = r_wdata;
    assign data_oe   = r_data_oe;
    assign wre       = r_wre;
    assign oute      = r_oute;
    assign chip_en   = r_chip_en;
    assign hb_mask   = r_hb_mask;
    assign lb_mask   = r_lb_mask;

endmodule
